handshake_tx: RTL and testbench

HANDSHAKE_TX -- requirements
Module: handshake_tx

---
 rtl/handshake_tx.sv | 93 +++++++++
 tb/tb_handshake_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/handshake_tx.sv
// Four-phase request/acknowledge transmitter with a synchronized ack input,
// registered payload and a per-phase timeout (TIMEOUT=0 disables it).
module handshake_tx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t        state;
    logic          ack_s1, ack_sync;
    logic [CW-1:0] cnt;
    logic          tmo;

    // ack_in is asynchronous to clk; nothing downstream may look at it raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1   <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_s1   <= ack_in;
            ack_sync <= ack_s1;
        end
    end

    assign tmo  = (TIMEOUT > 0) && (cnt == CW'(TMAX));
    assign busy = (state != IDLE) || ack_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (cnt != '1) cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (send && !ack_sync) begin
                        state    <= REQ;
                        req_out  <= 1'b1;
                        data_out <= data_in;
                        cnt      <= '0;
                    end
                end
                REQ: begin
                    // a normal exit takes priority over a coincident timeout
                    if (ack_sync) begin
                        state   <= REL;
                        req_out <= 1'b0;
                        cnt     <= '0;
                    end else if (tmo) begin
                        state   <= IDLE;
                        req_out <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                REL: begin
                    if (!ack_sync) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (tmo) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx: normal transfer, ignored send, timeout,
// timeout/ack coincidence, stale ack and asynchronous reset.
module tb_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] data_in;
    logic       ack_in;
    logic       req_out;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk = 0;
    int n_bad = 0;

    handshake_tx #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_send(input logic [7:0] d);
        send    = 1'b1;
        data_in = d;
        step(1);
        send    = 1'b0;
    endtask

    initial begin
        int hi;
        rst_n = 1'b0; send = 1'b0; data_in = '0; ack_in = 1'b0;
        #3;
        chk("rst_req",  req_out,  0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy,     0);
        chk("rst_done", {done, err}, 0);
        step(2);
        rst_n = 1'b1;

        // normal transfer
        do_send(8'hA5);
        chk("n_req",   req_out,  1);
        chk("n_data",  data_out, 8'hA5);
        chk("n_busy",  busy,     1);
        step(2);
        ack_in = 1'b1;
        step(1); chk("n_req_k",   req_out, 1);
        step(1); chk("n_req_k1",  req_out, 1);
        step(1); chk("n_req_k2",  req_out, 0);
        chk("n_data_rel", data_out, 8'hA5);
        chk("n_busy_rel", busy, 1);
        step(2);
        ack_in = 1'b0;
        step(2); chk("n_done_early", done, 0);
        step(1); chk("n_done", done, 1);
        chk("n_busy_idle", busy, 0);
        chk("n_err", err, 0);
        step(1); chk("n_done_1w", done, 0);

        // send during REQ is ignored
        do_send(8'h11);
        chk("ig_req", req_out, 1);
        do_send(8'h3C);
        chk("ig_data", data_out, 8'h11);
        ack_in = 1'b1;
        step(3); chk("ig_rel", req_out, 0);
        ack_in = 1'b0;
        step(3); chk("ig_done", done, 1);
        step(4);
        chk("ig_no2nd", req_out, 0);
        chk("ig_data2", data_out, 8'h11);

        // timeout with ack held low
        do_send(8'h5A);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (req_out) hi++;
            chk("to_err_low", err, 0);
            step(1);
        end
        chk("to_req_cycles", hi, 16);
        chk("to_req_drop", req_out, 0);
        chk("to_err", err, 1);
        chk("to_done", done, 0);
        chk("to_busy", busy, 0);
        step(1);
        chk("to_err_1w", err, 0);
        chk("to_data_hold", data_out, 8'h5A);

        // ack_sync reaches 1 exactly when the counter is at TIMEOUT-1
        do_send(8'h77);
        step(13);
        ack_in = 1'b1;
        step(2); chk("co_req", req_out, 1);
        step(1);
        chk("co_rel", req_out, 0);
        chk("co_err", err, 0);
        chk("co_busy", busy, 1);
        ack_in = 1'b0;
        step(3);
        chk("co_done", done, 1);
        chk("co_err2", err, 0);
        step(1);

        // stale ack blocks send
        ack_in = 1'b1;
        step(2);
        chk("st_busy", busy, 1);
        do_send(8'hC3);
        chk("st_req", req_out, 0);
        chk("st_data", data_out, 8'h77);
        ack_in = 1'b0;
        step(1); chk("st_busy1", busy, 1);
        step(1); chk("st_busy0", busy, 0);
        do_send(8'h96);
        chk("st_req2", req_out, 1);
        chk("st_data2", data_out, 8'h96);

        // asynchronous reset during REL
        ack_in = 1'b1;
        step(3);
        chk("rs_in_rel", {req_out, busy}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_data", data_out, 0);
        chk("rs_outs", {req_out, done, err, busy}, 0);
        ack_in = 1'b0;
        step(1);
        rst_n = 1'b1;

        // first edge after reset release accepts send; reset in REQ drops req_out
        do_send(8'h42);
        chk("rs_accept", req_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_req_async", req_out, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
